// File: rtl/chimera_pkg.sv
// Shared types and defaults for the Chimera cluster power sequencer.
// Holds the per-cluster state enum, parameter defaults and a counter-width helper.
package chimera_pkg;

    localparam int unsigned ExtClusters      = 5;
    localparam int unsigned DefRstCycles     = 8;
    localparam int unsigned DefTimeoutCycles = 1024;

    typedef enum logic [2:0] {
        PWR_OFF    = 3'd0,
        PWR_CLK_ON = 3'd1,
        PWR_DEISO  = 3'd2,
        PWR_ON     = 3'd3,
        PWR_ISO    = 3'd4,
        PWR_RST    = 3'd5
    } pwr_state_e;

    // One counter serves both the reset hold and the isolation timeout,
    // so it must hold the larger of the two limits without wrapping.
    function automatic int unsigned cnt_width(
        input int unsigned a,
        input int unsigned b
    );
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/chimera_cluster_pwr_fsm.sv
// Power sequencer for a single cluster domain (Moore FSM + shared counter).
// Ports: clk_i/rst_i, pwr_req_i, isolated_i, err_clr_i in; isolate_o,
// clk_en_o, cluster_rst_no, pwr_ack_o, busy_o, err_o out.
module chimera_cluster_pwr_fsm
    import chimera_pkg::*;
#(
    parameter int unsigned RstCycles     = DefRstCycles,
    parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pwr_req_i,
    input  logic isolated_i,
    input  logic err_clr_i,
    output logic isolate_o,
    output logic clk_en_o,
    output logic cluster_rst_no,
    output logic pwr_ack_o,
    output logic busy_o,
    output logic err_o
);

    localparam int unsigned CntW = cnt_width(RstCycles, TimeoutCycles);

    // Hold counters load RstCycles-1 on entry and leave when they hit 0,
    // which gives exactly RstCycles cycles in CLK_ON / RST.
    localparam logic [CntW-1:0] RstLoad = CntW'(RstCycles - 1);
    localparam logic [CntW-1:0] TmoMax  = CntW'(TimeoutCycles);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    pwr_state_e      r_state;
    pwr_state_e      w_state_nxt;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;
    logic [CntW-1:0] w_cnt_sat;
    logic            r_err;
    logic            w_err_set;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= PWR_OFF;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // set wins over a simultaneous clear
            r_err   <= w_err_set | (r_err & ~err_clr_i);
        end
    end

    // saturating up-count while waiting on the isolation handshake
    assign w_cnt_sat = (r_cnt == TmoMax) ? r_cnt : r_cnt + CntOne;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_set   = 1'b0;
        unique case (r_state)
            PWR_OFF: begin
                if (pwr_req_i) begin
                    w_state_nxt = PWR_CLK_ON;
                    w_cnt_nxt   = RstLoad;
                end
            end
            PWR_CLK_ON: begin
                if (r_cnt == '0) begin
                    w_state_nxt = PWR_DEISO;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CntOne;
                end
            end
            PWR_DEISO: begin
                if (!isolated_i) begin
                    w_state_nxt = PWR_ON;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_sat;
                    w_err_set = (r_cnt == TmoMax - CntOne);
                end
            end
            PWR_ON: begin
                if (!pwr_req_i) begin
                    w_state_nxt = PWR_ISO;
                    w_cnt_nxt   = '0;
                end
            end
            PWR_ISO: begin
                if (isolated_i) begin
                    w_state_nxt = PWR_RST;
                    w_cnt_nxt   = RstLoad;
                end else begin
                    w_cnt_nxt = w_cnt_sat;
                    w_err_set = (r_cnt == TmoMax - CntOne);
                end
            end
            PWR_RST: begin
                if (r_cnt == '0) begin
                    w_state_nxt = PWR_OFF;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CntOne;
                end
            end
            default: begin
                w_state_nxt = PWR_OFF;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        isolate_o      = 1'b1;
        clk_en_o       = 1'b0;
        cluster_rst_no = 1'b0;
        pwr_ack_o      = 1'b0;
        busy_o         = 1'b0;
        unique case (r_state)
            PWR_OFF: begin
                isolate_o = 1'b1;
            end
            PWR_CLK_ON, PWR_RST: begin
                clk_en_o = 1'b1;
                busy_o   = 1'b1;
            end
            PWR_DEISO: begin
                isolate_o      = 1'b0;
                clk_en_o       = 1'b1;
                cluster_rst_no = 1'b1;
                busy_o         = 1'b1;
            end
            PWR_ON: begin
                isolate_o      = 1'b0;
                clk_en_o       = 1'b1;
                cluster_rst_no = 1'b1;
                pwr_ack_o      = 1'b1;
            end
            PWR_ISO: begin
                clk_en_o       = 1'b1;
                cluster_rst_no = 1'b1;
                busy_o         = 1'b1;
            end
            default: begin
                isolate_o = 1'b1;
            end
        endcase
    end

    assign err_o = r_err;

endmodule

// File: rtl/chimera_cluster_pwr_seq.sv
// Top-level power sequencer: one independent FSM per cluster domain.
// Ports: clk_i/rst_i; per-cluster pwr_req_i, isolated_i, err_clr_i in;
// isolate_o, clk_en_o, cluster_rst_no, pwr_ack_o, busy_o, err_o out.
module chimera_cluster_pwr_seq
    import chimera_pkg::*;
#(
    parameter int unsigned NumClusters   = ExtClusters,
    parameter int unsigned RstCycles     = DefRstCycles,
    parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumClusters-1:0] pwr_req_i,
    input  logic [NumClusters-1:0] isolated_i,
    input  logic [NumClusters-1:0] err_clr_i,
    output logic [NumClusters-1:0] isolate_o,
    output logic [NumClusters-1:0] clk_en_o,
    output logic [NumClusters-1:0] cluster_rst_no,
    output logic [NumClusters-1:0] pwr_ack_o,
    output logic [NumClusters-1:0] busy_o,
    output logic [NumClusters-1:0] err_o
);

    for (genvar g = 0; g < NumClusters; g++) begin : g_cluster
        chimera_cluster_pwr_fsm #(
            .RstCycles     (RstCycles),
            .TimeoutCycles (TimeoutCycles)
        ) u_fsm (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .pwr_req_i      (pwr_req_i[g]),
            .isolated_i     (isolated_i[g]),
            .err_clr_i      (err_clr_i[g]),
            .isolate_o      (isolate_o[g]),
            .clk_en_o       (clk_en_o[g]),
            .cluster_rst_no (cluster_rst_no[g]),
            .pwr_ack_o      (pwr_ack_o[g]),
            .busy_o         (busy_o[g]),
            .err_o          (err_o[g])
        );
    end

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Self-checking bench for chimera_cluster_pwr_seq.
// Table vectors, directed corner sequences and randomized traffic vs a model.
module tb_chimera_cluster_pwr_seq;

    localparam int N   = 5;
    localparam int RC  = 8;
    localparam int TMO = 16;

    localparam int M_OFF  = 0;
    localparam int M_WAKE = 1;
    localparam int M_DEI  = 2;
    localparam int M_ON   = 3;
    localparam int M_ISO  = 4;
    localparam int M_RST  = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req, iso, clr;
    logic [N-1:0] iso_o, clk_en, rstn, ack, busy, err;

    always #5 clk = ~clk;

    chimera_cluster_pwr_seq #(
        .NumClusters   (N),
        .RstCycles     (RC),
        .TimeoutCycles (TMO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pwr_req_i      (req),
        .isolated_i     (iso),
        .err_clr_i      (clr),
        .isolate_o      (iso_o),
        .clk_en_o       (clk_en),
        .cluster_rst_no (rstn),
        .pwr_ack_o      (ack),
        .busy_o         (busy),
        .err_o          (err)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // model: which phase each cluster is in, and how long it has been there
    int ph[N];
    int el[N];
    bit merr[N];

    typedef struct {
        bit       req;
        bit       isol;
        bit [5:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cycle, got, exp);
        end
    endtask

    // {isolate, clk_en, rst_n, ack, busy} per phase
    function automatic logic [4:0] outs(input int p);
        case (p)
            M_OFF:   return 5'b10000;
            M_WAKE:  return 5'b11001;
            M_DEI:   return 5'b01101;
            M_ON:    return 5'b01110;
            M_ISO:   return 5'b11101;
            default: return 5'b11001;
        endcase
    endfunction

    task automatic model_step();
        for (int c = 0; c < N; c++) begin
            bit set;
            set = 1'b0;
            if (rst) begin
                ph[c] = M_OFF;
                el[c] = 0;
                merr[c] = 1'b0;
            end else begin
                el[c]++;
                case (ph[c])
                    M_OFF: if (req[c]) begin ph[c] = M_WAKE; el[c] = 0; end
                    M_WAKE: if (el[c] == RC) begin ph[c] = M_DEI; el[c] = 0; end
                    M_DEI: begin
                        if (!iso[c]) begin ph[c] = M_ON; el[c] = 0; end
                        else if (el[c] == TMO) set = 1'b1;
                    end
                    M_ON: if (!req[c]) begin ph[c] = M_ISO; el[c] = 0; end
                    M_ISO: begin
                        if (iso[c]) begin ph[c] = M_RST; el[c] = 0; end
                        else if (el[c] == TMO) set = 1'b1;
                    end
                    default: if (el[c] == RC) begin ph[c] = M_OFF; el[c] = 0; end
                endcase
                if (set) merr[c] = 1'b1;
                else if (clr[c]) merr[c] = 1'b0;
            end
        end
    endtask

    task automatic check_model();
        logic [N-1:0] e_iso, e_clk, e_rstn, e_ack, e_busy, e_err;
        logic [4:0] o;
        for (int c = 0; c < N; c++) begin
            o = outs(ph[c]);
            e_iso[c]  = o[4];
            e_clk[c]  = o[3];
            e_rstn[c] = o[2];
            e_ack[c]  = o[1];
            e_busy[c] = o[0];
            e_err[c]  = merr[c];
        end
        chk("model", 64'({iso_o, clk_en, rstn, ack, busy, err}),
            64'({e_iso, e_clk, e_rstn, e_ack, e_busy, e_err}));
    endtask

    // inputs already driven; advance one edge and check at the negedge
    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cycle++;
        check_model();
    endtask

    task automatic add(input bit r, input bit i, input bit [5:0] e);
        vec_t v;
        v.req = r;
        v.isol = i;
        v.exp = e;
        tbl.push_back(v);
    endtask

    localparam bit [5:0] V_CON = 6'b110010;
    localparam bit [5:0] V_DEI = 6'b011010;
    localparam bit [5:0] V_ON  = 6'b011100;
    localparam bit [5:0] V_ISO = 6'b111010;
    localparam bit [5:0] V_RST = 6'b110010;
    localparam bit [5:0] V_OFF = 6'b100000;

    initial begin
        int k, t0, t4;
        for (int c = 0; c < N; c++) begin
            ph[c] = M_OFF;
            el[c] = 0;
            merr[c] = 1'b0;
        end
        rst = 1'b1;
        req = '0;
        iso = '1;
        clr = '0;
        @(negedge clk);
        cyc();
        cyc();
        chk("reset", 64'({iso_o, clk_en, rstn, ack, busy, err}),
            64'({5'h1f, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0}));
        rst = 1'b0;

        // power-on with delayed isolation follower, then power-off
        for (int i = 0; i < 8; i++) add(1, 1, V_CON);
        add(1, 1, V_DEI);
        add(1, 1, V_DEI);
        add(1, 0, V_ON);
        add(0, 0, V_ISO);
        for (int i = 0; i < 8; i++) add(0, 1, V_RST);
        add(0, 1, V_OFF);
        add(0, 1, V_OFF);
        // minimum latency when isolation already released
        for (int i = 0; i < 8; i++) add(1, 0, V_CON);
        add(1, 0, V_DEI);
        add(1, 0, V_ON);
        add(0, 1, V_ISO);
        for (int i = 0; i < 8; i++) add(0, 1, V_RST);
        add(0, 1, V_OFF);
        for (int i = 0; i < tbl.size(); i++) begin
            req[0] = tbl[i].req;
            iso[0] = tbl[i].isol;
            cyc();
            chk($sformatf("tbl%0d", i),
                64'({iso_o[0], clk_en[0], rstn[0], ack[0], busy[0], err[0]}),
                64'(tbl[i].exp));
        end
        iso[0] = 1'b1;

        // isolation timeout on cluster 3, set/clear collision, then clear
        req[3] = 1'b1;
        iso[3] = 1'b0;
        repeat (10) cyc();
        chk("tmo_on", 64'(ack[3]), 64'(1));
        req[3] = 1'b0;
        cyc();
        repeat (15) cyc();
        chk("tmo_pre", 64'(err[3]), 64'(0));
        clr[3] = 1'b1;
        cyc();
        clr[3] = 1'b0;
        chk("tmo_set", 64'({err[3], busy[3], iso_o[3]}), 64'(3'b111));
        repeat (4) cyc();
        chk("tmo_wait", 64'({err[3], busy[3]}), 64'(2'b11));
        iso[3] = 1'b1;
        repeat (9) cyc();
        chk("tmo_off", 64'({iso_o[3], clk_en[3], busy[3], err[3]}), 64'(4'b1001));
        clr[3] = 1'b1;
        cyc();
        clr[3] = 1'b0;
        chk("tmo_clr", 64'(err[3]), 64'(0));

        // request dropped during CLK_ON: ON is still reached, then ISO
        req[1] = 1'b1;
        iso[1] = 1'b0;
        repeat (3) cyc();
        req[1] = 1'b0;
        k = 3;
        while (!ack[1] && k < 40) begin
            cyc();
            k++;
        end
        chk("tog_lat", 64'(k), 64'(RC + 2));
        cyc();
        chk("tog_iso", 64'({ack[1], busy[1], iso_o[1]}), 64'(3'b011));
        iso[1] = 1'b1;
        repeat (12) cyc();

        // reset while cluster 1 in DEISO and cluster 0 ON
        req[0] = 1'b1;
        iso[0] = 1'b0;
        req[1] = 1'b1;
        iso[1] = 1'b1;
        repeat (10) cyc();
        chk("pre_rst", 64'({ack[0], rstn[1], busy[1]}), 64'(3'b111));
        rst = 1'b1;
        cyc();
        chk("mid_rst", 64'({iso_o, clk_en, rstn, ack, busy, err}),
            64'({5'h1f, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0}));
        rst = 1'b0;
        req = '0;
        iso = '1;
        cyc();

        // independent schedules for clusters 0 and 4
        req[0] = 1'b1;
        req[4] = 1'b1;
        t0 = -1;
        t4 = -1;
        for (int i = 0; i < 30; i++) begin
            iso[0] = (i >= 10) ? 1'b0 : 1'b1;
            iso[4] = (i >= 14) ? 1'b0 : 1'b1;
            cyc();
            if (ack[0] && t0 < 0) t0 = i;
            if (ack[4] && t4 < 0) t4 = i;
        end
        chk("ind_c0", 64'(t0), 64'(10));
        chk("ind_c4", 64'(t4), 64'(14));
        chk("ind_idle", 64'({ack[1], ack[2], ack[3]}), 64'(0));

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 15) == 0) req[c] = ~req[c];
                if ($urandom_range(0, 9) == 0) iso[c] = ~iso[c];
                clr[c] = ($urandom_range(0, 24) == 0);
            end
            rst = ($urandom_range(0, 399) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chimera_cluster_pwr_seq.md
CHIMERA_CLUSTER_PWR_SEQ -- requirements
Module: chimera_cluster_pwr_seq

Interface
REQ-001 SHALL have parameter NumClusters, default ExtClusters (5), number of independently sequenced cluster domains.
REQ-002 SHALL have parameter RstCycles, default 8, number of cycles cluster reset is held with clock running (range 1..255).
REQ-003 SHALL have parameter TimeoutCycles, default 1024, isolation-handshake wait limit before error flag.
REQ-004 SHALL have port clk_i  in  1  single clock for all logic.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port pwr_req_i  in  NumClusters  level request per cluster from top-level cfg regs (1 = on, 0 = off).
REQ-007 SHALL have port isolated_i  in  NumClusters  per-cluster AXI isolate status (1 = drained and isolated).
REQ-008 SHALL have port err_clr_i  in  NumClusters  single-cycle clear of sticky error, per cluster.
REQ-009 SHALL have port isolate_o  out  NumClusters  per-cluster AXI isolate request.
REQ-010 SHALL have port clk_en_o  out  NumClusters  per-cluster clock-gate enable.
REQ-011 SHALL have port cluster_rst_no  out  NumClusters  per-cluster reset, active-low.
REQ-012 SHALL have port pwr_ack_o  out  NumClusters  1 only in state ON.
REQ-013 SHALL have port busy_o  out  NumClusters  1 in any transitional state.
REQ-014 SHALL have port err_o  out  NumClusters  sticky isolation-timeout flag.

Function
REQ-015 SHALL run one independent FSM per cluster with states OFF, CLK_ON, DEISO, ON, ISO, RST.
REQ-016 SHALL drive outputs from registered state only (Moore): OFF: isolate=1, clk_en=0, rst_n=0; CLK_ON: 1,1,0; DEISO: 0,1,1; ON: 0,1,1; ISO: 1,1,1; RST: 1,1,0.
REQ-017 SHALL transition OFF->CLK_ON on the edge where pwr_req_i=1.
REQ-018 SHALL stay in CLK_ON exactly RstCycles cycles (counter loaded on entry), then go to DEISO.
REQ-019 SHALL go DEISO->ON on the edge where isolated_i=0.
REQ-020 SHALL transition ON->ISO on the edge where pwr_req_i=0.
REQ-021 SHALL go ISO->RST on the edge where isolated_i=1.
REQ-022 SHALL stay in RST exactly RstCycles cycles, then go to OFF.
REQ-023 SHALL sample pwr_req_i only in OFF and ON; request changes during transitional states are ignored until a stable state is reached, then acted on next edge.
REQ-024 SHALL count cycles in ISO and DEISO; on reaching TimeoutCycles set err_o (sticky) and keep waiting in the same state; counter saturates.
REQ-025 SHALL clear err_o on err_clr_i=1; a simultaneous set and clear SHALL leave err_o=1.
REQ-026 SHALL give minimum power-on latency (req edge to pwr_ack_o=1) of RstCycles+2 cycles when isolated_i is already 0.
REQ-027 SHALL size the shared counter to $clog2(max(RstCycles,TimeoutCycles)+1) bits, with no wrap-around.

Reset
REQ-028 SHALL on rst_i=1 force every FSM to OFF, counters to 0, err_o to 0, giving isolate_o=all 1, clk_en_o=0, cluster_rst_no=0, pwr_ack_o=0, busy_o=0 from the next edge.
REQ-029 SHALL abort any sequence in progress on rst_i mid-operation, with no intermediate states traversed.

Structure
REQ-030 SHALL place the state enum type and RstCycles/TimeoutCycles defaults in chimera_pkg.
REQ-031 SHALL implement the per-cluster FSM as sub-module chimera_cluster_pwr_fsm, instantiated NumClusters times by a generate loop.

Verification
REQ-032 SHALL cover power-on: RstCycles=8, isolated_i follows isolate_o after 1 cycle, pwr_req_i[0] 0->1 -> clk_en_o[0]=1 at +1, cluster_rst_no[0]=1 at +9, pwr_ack_o[0]=1 at +11.
REQ-033 SHALL cover power-off: from ON, pwr_req_i[2]=0, isolated_i[2] raised 5 cycles after isolate_o -> RST 8 cycles, then clk_en_o[2]=0, isolate_o[2]=1.
REQ-034 SHALL cover timeout: TimeoutCycles=16, isolated_i held 0 in ISO -> err_o=1 at cycle 16; isolated_i then 1 -> RST/OFF reached normally; err_clr_i pulse -> err_o=0.
REQ-035 SHALL cover request toggle in CLK_ON: pwr_req_i 1 then 0 after 3 cycles -> ON reached, then ISO entered next edge.
REQ-036 SHALL cover rst_i asserted in DEISO on cluster 1 while cluster 0 is ON -> all clusters OFF with reset-value outputs next cycle.
REQ-037 SHALL cover independence: simultaneous on-request for clusters 0 and 4 with different isolated_i timing -> each reaches ON on its own schedule.
